// File: rtl/inst_fetch_unit_pkg.sv
// Shared MIPS core definitions: instruction field positions, common opcodes and the fetch FSM/PC-select types.
// Latency: none; this package holds only types and constants.
// Backpressure: not applicable.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;

    // Instruction field positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    // Encodings also used by the control unit
    localparam logic [5:0] OPC_RTYPE    = 6'b000000;
    localparam logic [5:0] FUNC_SYSCALL = 6'b001100;
    localparam logic [5:0] FUNC_ADD     = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundles the instruction-memory read port and the decoder-facing instruction port of the fetch unit.
// Latency: none; wires only.
// Backpressure: mem_req held until mem_valid; inst_valid held until inst_ready.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = mips_pkg::ADDR_W_DEF,
    parameter int INST_W = mips_pkg::INST_W_DEF
);
    // Instruction memory side
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_rdata;
    logic              mem_valid;

    // Decoder side
    logic [INST_W-1:0] inst;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              halted;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_halted;

    modport master (
        output mem_req, mem_addr, inst, opcode, func, inst_pc, inst_valid, fetch_halted,
        input  mem_rdata, mem_valid, inst_ready, halted, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst, opcode, func, inst_pc, inst_valid, fetch_halted,
        output mem_rdata, mem_valid, inst_ready, halted, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_unit_pc_reg.sv
// Program counter register: reset load, +4 sequential advance from the delivered PC, or word-aligned redirect.
// Latency: new PC visible one cycle after the select is applied.
// Backpressure: none; holds its value whenever the select is PC_HOLD.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // PC update; the +4 wraps naturally modulo 2^ADDR_W, redirect targets lose their byte offset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            unique case (sel)
                PC_INC:   pc <= inst_pc + PC_STEP;
                PC_REDIR: pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
                default:  pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: issues one word read at PC, buffers the returned instruction and hands it to the decoder.
// Latency: inst_valid rises the cycle after mem_valid; next fetch starts the cycle after a decoder transfer.
// Backpressure: holds the buffered instruction stable while inst_ready is low; no fetch overlaps delivery.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    inst_fetch_unit_if.master   bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    pc_sel_t           pc_sel;
    logic              capture;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .sel         (pc_sel),
        .inst_pc     (inst_pc_q),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC select and capture strobe; halted/redirect only matter on an actual transfer
    always_comb begin
        state_d = state_q;
        pc_sel  = PC_HOLD;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_valid) begin
                    capture = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (bus.inst_ready) begin
                    if (bus.halted) begin
                        state_d = ST_HALT;
                    end else if (bus.redirect) begin
                        pc_sel  = PC_REDIR;
                        state_d = ST_FETCH;
                    end else begin
                        pc_sel  = PC_INC;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // One-entry instruction buffer, loaded only by the response to our own request
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else if (capture) begin
            inst_q    <= bus.mem_rdata;
            inst_pc_q <= pc;
        end
    end

    // All handshake outputs decode from registered state, so inst_ready never reaches mem_req combinationally
    assign bus.mem_req      = (state_q == ST_FETCH);
    assign bus.mem_addr     = pc;
    assign bus.inst_valid   = (state_q == ST_DELIVER);
    assign bus.fetch_halted = (state_q == ST_HALT);
    assign bus.inst         = inst_q;
    assign bus.inst_pc      = inst_pc_q;
    assign bus.opcode       = inst_q[OPC_MSB:OPC_LSB];
    assign bus.func         = inst_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, decoder stall, redirect, halt, PC wrap, reset mid-fetch.
// Latency: memory responses are generated with a programmable delay after mem_req is seen.
// Backpressure: inst_ready is driven per step to exercise stalls.
module tb_inst_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

    inst_fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a fetch request and checks its address
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, exp_addr);
    endtask

    // Returns data lat cycles after the request cycle; leaves the bench at the first DELIVER negedge
    task automatic respond(input string tag, input int lat, input logic [31:0] data);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_req_held"}, {31'd0, bus.mem_req}, 32'd1);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_rdata = $urandom;
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] data, input logic [31:0] pc);
        chk({tag, "_vld"}, {31'd0, bus.inst_valid}, 32'd1);
        chk({tag, "_inst"}, bus.inst, data);
        chk({tag, "_opc"}, {26'd0, bus.opcode}, {26'd0, data[31:26]});
        chk({tag, "_func"}, {26'd0, bus.func}, {26'd0, data[5:0]});
        chk({tag, "_pc"}, bus.inst_pc, pc);
        chk({tag, "_req_low"}, {31'd0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        bus.mem_valid   = 1'b0;
        bus.mem_rdata   = '0;
        bus.inst_ready  = 1'b0;
        bus.halted      = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_halt", {31'd0, bus.fetch_halted}, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_ipc", bus.inst_pc, 32'd0);

        // Sequential fetch, latency 1, decoder always ready
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        wait_req("seq0", 32'h0000_0000);
        respond("seq0", 1, 32'h0022_1820);
        chk_inst("seq0", 32'h0022_1820, 32'h0000_0000);
        @(negedge clk);
        chk("seq0_vld_pulse", {31'd0, bus.inst_valid}, 32'd0);
        wait_req("seq1", 32'h0000_0004);
        respond("seq1", 1, 32'h8C43_0004);
        chk_inst("seq1", 32'h8C43_0004, 32'h0000_0004);
        @(negedge clk);
        wait_req("seq2", 32'h0000_0008);
        respond("seq2", 1, 32'h2002_000A);
        chk_inst("seq2", 32'h2002_000A, 32'h0000_0008);
        @(negedge clk);

        // Latency 3, decoder stalls 4 cycles in DELIVER
        wait_req("stall", 32'h0000_000C);
        bus.inst_ready = 1'b0;
        respond("stall", 3, 32'h1062_FFFF);
        for (int i = 0; i < 4; i++) begin
            chk_inst("stall_hold", 32'h1062_FFFF, 32'h0000_000C);
            @(negedge clk);
        end
        chk_inst("stall_end", 32'h1062_FFFF, 32'h0000_000C);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        wait_req("after_stall", 32'h0000_0010);

        // Redirect at 0x10; halted/redirect without ready must be ignored first
        respond("redir", 2, 32'h0800_0040);
        chk_inst("redir", 32'h0800_0040, 32'h0000_0010);
        bus.inst_ready  = 1'b0;
        bus.halted      = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("noready_vld", {31'd0, bus.inst_valid}, 32'd1);
        chk("noready_halt", {31'd0, bus.fetch_halted}, 32'd0);
        bus.halted     = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("redir_vld", {31'd0, bus.inst_valid}, 32'd0);
        wait_req("redir_tgt", 32'h0000_0100);

        // Redirect to top of address space, then wrap
        respond("wrap0", 1, 32'h0800_0000);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.redirect = 1'b0;
        wait_req("wrap_top", 32'hFFFF_FFFC);
        respond("wrap1", 1, 32'h0000_0000);
        chk_inst("wrap1", 32'h0000_0000, 32'hFFFF_FFFC);
        @(negedge clk);
        wait_req("wrap_zero", 32'h0000_0000);

        // SYSCALL with simultaneous redirect: halt wins and sticks
        respond("sys", 1, 32'h0000_000C);
        chk_inst("sys", 32'h0000_000C, 32'h0000_0000);
        bus.halted      = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        @(negedge clk);
        bus.halted   = 1'b0;
        bus.redirect = 1'b0;
        chk("halt_flag", {31'd0, bus.fetch_halted}, 32'd1);
        chk("halt_vld", {31'd0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.redirect  = i[0];
            bus.halted    = i[1];
            bus.mem_valid = i[2];
            @(negedge clk);
            chk("halt_req", {31'd0, bus.mem_req}, 32'd0);
            chk("halt_sticky", {31'd0, bus.fetch_halted}, 32'd1);
        end
        bus.redirect  = 1'b0;
        bus.halted    = 1'b0;
        bus.mem_valid = 1'b0;

        // Reset out of HALT, then reset again in the middle of a fetch
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("unhalt_flag", {31'd0, bus.fetch_halted}, 32'd0);
        wait_req("post_rst", 32'h0000_0000);
        @(negedge clk);
        chk("midfetch_req", {31'd0, bus.mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst_vld", {31'd0, bus.inst_valid}, 32'd0);
        reset         = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("late_vld", {31'd0, bus.inst_valid}, 32'd0);
        chk("late_inst", bus.inst, 32'd0);
        wait_req("refetch", 32'h0000_0000);
        respond("refetch", 1, 32'h012A_4020);
        chk_inst("refetch", 32'h012A_4020, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
